// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported data memory: instruction fetch
// (read-only) and load/store, one word access per cycle, registered responses.
module mem_port_arbiter #(
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  localparam int PORTS = 2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  grant_e      last_grant_reg;
  logic [3:0]  starve_cnt_reg;
  logic        if_win;
  logic        ls_win;
  logic [PORTS-1:0] gnt;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        misaligned;

  logic        rsp_valid_reg [PORTS];
  logic [31:0] rdata_reg     [PORTS];
  logic        err_reg       [PORTS];

  // Grants are combinational from the requests; reset holds everything idle.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (ARB_MODE == 0) begin
          if_win = (starve_cnt_reg == STARVE_LIM);
        end else begin
          if_win = (last_grant_reg == GRANT_LS);
        end
        ls_win = ~if_win;
      end else begin
        if_win = if_req;
        ls_win = ls_req;
      end
    end
  end

  assign gnt = {ls_win, if_win};

  always_comb begin
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    sel_we    = 1'b0;
    if (if_win) begin
      sel_addr = if_addr;
    end else if (ls_win) begin
      sel_addr  = ls_addr;
      sel_wdata = ls_wdata;
      sel_we    = ls_we;
    end
  end

  // Misaligned accesses are still granted but never reach the memory.
  assign misaligned = (sel_addr[1:0] != 2'b00);
  assign mem_addr   = sel_addr;
  assign mem_wdata  = sel_wdata;
  assign mem_read   = (if_win | ls_win) & ~sel_we & ~misaligned;
  assign mem_write  = (if_win | ls_win) &  sel_we & ~misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= GRANT_IF;
      starve_cnt_reg <= 4'd0;
    end else begin
      if (if_win) begin
        last_grant_reg <= GRANT_IF;
      end else if (ls_win) begin
        last_grant_reg <= GRANT_LS;
      end
      if (!if_req || if_win) begin
        starve_cnt_reg <= 4'd0;
      end else if (starve_cnt_reg != STARVE_LIM) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end

  // mem_read is only ever raised for the current winner, so it also filters
  // stores and misaligned accesses down to a zero response word.
  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_rsp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_reg[gi] <= 1'b0;
          rdata_reg[gi]     <= 32'h0;
          err_reg[gi]       <= 1'b0;
        end else begin
          rsp_valid_reg[gi] <= gnt[gi];
          err_reg[gi]       <= gnt[gi] & misaligned;
          rdata_reg[gi]     <= (gnt[gi] && mem_read) ? mem_rdata : 32'h0;
        end
      end
    end
  endgenerate

  assign if_gnt       = if_win;
  assign ls_gnt       = ls_win;
  assign if_rsp_valid = rsp_valid_reg[0];
  assign if_rdata     = rdata_reg[0];
  assign if_err       = err_reg[0];
  assign ls_rsp_valid = rsp_valid_reg[1];
  assign ls_rdata     = rdata_reg[1];
  assign ls_err       = err_reg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority instance with a memory
// model and response scoreboard, plus a round-robin instance for grant order.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rsp_valid, if_err;
  logic [31:0] if_rdata;
  logic        ls_gnt, ls_rsp_valid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1, ls_req1;
  logic        if_gnt1, if_rsp_valid1, if_err1;
  logic [31:0] if_rdata1;
  logic        ls_gnt1, ls_rsp_valid1, ls_err1;
  logic [31:0] ls_rdata1;
  logic        mem_read1, mem_write1;
  logic [31:0] mem_addr1, mem_wdata1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t ls_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [64];

  mem_port_arbiter #(.ARB_MODE(0), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ARB_MODE(1), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(32'h10), .if_gnt(if_gnt1),
    .if_rsp_valid(if_rsp_valid1), .if_rdata(if_rdata1), .if_err(if_err1),
    .ls_req(ls_req1), .ls_we(1'b0), .ls_addr(32'h30), .ls_wdata(32'h0),
    .ls_gnt(ls_gnt1), .ls_rsp_valid(ls_rsp_valid1), .ls_rdata(ls_rdata1), .ls_err(ls_err1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(32'h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: every rsp pulse must match the oldest expected entry.
  always @(negedge clk) begin
    rsp_t e;
    if (if_rsp_valid) begin
      if (if_q.size() == 0) begin
        check("if_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = if_q.pop_front();
        check("if_rdata", if_rdata, e.rdata);
        check("if_err", {31'b0, if_err}, {31'b0, e.err});
        $display("if rsp: rdata=%h err=%0b", if_rdata, if_err);
      end
    end
    if (ls_rsp_valid) begin
      if (ls_q.size() == 0) begin
        check("ls_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = ls_q.pop_front();
        check("ls_rdata", ls_rdata, e.rdata);
        check("ls_err", {31'b0, ls_err}, {31'b0, e.err});
        $display("ls rsp: rdata=%h err=%0b", ls_rdata, ls_err);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[4]  <= 32'hCAFE0001;
    mem[12] <= 32'h5A5A1234;
    rst_n    = 1'b0;
    if_req   = 1'b1;
    ls_req   = 1'b1;
    ls_we    = 1'b0;
    if_addr  = 32'h10;
    ls_addr  = 32'h30;
    ls_wdata = 32'h0;
    if_req1  = 1'b1;
    ls_req1  = 1'b1;

    // Reset held with both requests high
    repeat (2) begin
      @(negedge clk);
      check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
      check("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
      check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      check("rst_rsp", {30'b0, if_rsp_valid, ls_rsp_valid}, 32'd0);
      check("rst_rr_gnt", {30'b0, if_gnt1, ls_gnt1}, 32'd0);
    end
    $display("reset: grants and strobes idle");
    next_cycle();
    if_req  = 1'b0;
    ls_req  = 1'b0;
    if_req1 = 1'b0;
    ls_req1 = 1'b0;
    #2 rst_n = 1'b1;

    // Idle port
    @(negedge clk);
    check("idle_addr", mem_addr, 32'h0);
    check("idle_strobes", {30'b0, mem_read, mem_write}, 32'd0);

    // Fetch alone
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    check("if_alone_gnt", {31'b0, if_gnt}, 32'd1);
    check("if_alone_mem_read", {31'b0, mem_read}, 32'd1);
    check("if_alone_mem_addr", mem_addr, 32'h10);
    if_q.push_back('{rdata: 32'hCAFE0001, err: 1'b0});
    $display("fetch 0x10 granted");
    next_cycle();
    if_req = 1'b0;

    // Both requesting: fixed priority with starvation guard, and round-robin
    next_cycle();
    if_req  = 1'b1;
    ls_req  = 1'b1;
    if_addr = 32'h10;
    ls_addr = 32'h30;
    ls_we   = 1'b0;
    if_req1 = 1'b1;
    ls_req1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic exp_if;
      logic exp_if_rr;
      exp_if    = ((k % 5) == 4);
      exp_if_rr = ((k % 2) == 1);
      @(negedge clk);
      check("prio_if_gnt", {31'b0, if_gnt}, {31'b0, exp_if});
      check("prio_ls_gnt", {31'b0, ls_gnt}, {31'b0, ~exp_if});
      check("rr_if_gnt", {31'b0, if_gnt1}, {31'b0, exp_if_rr});
      check("rr_ls_gnt", {31'b0, ls_gnt1}, {31'b0, ~exp_if_rr});
      if (exp_if) if_q.push_back('{rdata: 32'hCAFE0001, err: 1'b0});
      else        ls_q.push_back('{rdata: 32'h5A5A1234, err: 1'b0});
      $display("cycle %0d: prio if=%0b ls=%0b rr if=%0b ls=%0b", k, if_gnt, ls_gnt, if_gnt1, ls_gnt1);
      next_cycle();
    end
    if_req  = 1'b0;
    ls_req  = 1'b0;
    if_req1 = 1'b0;
    ls_req1 = 1'b0;

    // Store then load back-to-back
    next_cycle();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h20;
    ls_wdata = 32'h12345678;
    @(negedge clk);
    check("st_gnt", {31'b0, ls_gnt}, 32'd1);
    check("st_strobes", {30'b0, mem_read, mem_write}, 32'd1);
    check("st_wdata", mem_wdata, 32'h12345678);
    ls_q.push_back('{rdata: 32'h0, err: 1'b0});
    $display("store 0x20 <= 12345678");
    next_cycle();
    ls_we = 1'b0;
    @(negedge clk);
    check("ld_gnt", {31'b0, ls_gnt}, 32'd1);
    check("ld_strobes", {30'b0, mem_read, mem_write}, 32'd2);
    ls_q.push_back('{rdata: 32'h12345678, err: 1'b0});
    $display("load 0x20");
    next_cycle();

    // Misaligned load
    ls_addr = 32'h22;
    @(negedge clk);
    check("mis_gnt", {31'b0, ls_gnt}, 32'd1);
    check("mis_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    ls_q.push_back('{rdata: 32'h0, err: 1'b1});
    $display("misaligned load 0x22");
    next_cycle();
    ls_req = 1'b0;

    // Reset while a fetch response is pending: it must be dropped
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    check("pre_rst_gnt", {31'b0, if_gnt}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check("rst_drop_rsp", {31'b0, if_rsp_valid}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_rsp", {31'b0, if_rsp_valid}, 32'd0);
    $display("reset mid-access: response dropped");

    repeat (2) @(negedge clk);
    check("if_q_drained", if_q.size(), 32'd0);
    check("ls_q_drained", ls_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
